// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: transmit-side serializer of the SPI master.
// Takes one parallel word over valid/ready and shifts it out MSB-first in
// SPI mode 0 (sclk idles low, data stable across the rising edge).
// The block generates sclk_out and cs_n_out itself. mosi_out and sel_out feed
// the SPI output mux: sel_out=0 selects this serializer, sel_out=1 the idle path.
// Every output is a flop. The next-state logic below computes the next value
// of each output, so the outputs change on the same edge as the state.
module spi_tx_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  sclk_out,
  output logic                  cs_n_out,
  output logic                  mosi_out,
  output logic                  sel_out
);

  // The divider needs at least one bit, so CLK_DIV=1 still gets a legal
  // counter. With one bit the terminal count is 0 and the compare cannot underflow.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t r_state, w_stateNext;

  // mosi_out is the MSB of the shift register. Loading, shifting and clearing
  // the register therefore also produces the serial data line.
  logic [DATA_WIDTH-1:0] r_shiftReg, w_shiftNext;
  logic [BIT_W-1:0]      r_bitCnt, w_bitNext;
  logic [CNT_W-1:0]      r_divCnt, w_divNext;

  logic r_ready, w_readyNext;
  logic r_busy, w_busyNext;
  logic r_done, w_doneNext;
  logic r_sclk, w_sclkNext;
  logic r_csN, w_csNNext;
  logic r_sel, w_selNext;

  logic w_divLast;

  assign w_divLast = (r_divCnt == DIV_LAST);

  // Next-state and next-output logic; every state holds for CLK_DIV cycles except IDLE/DONE
  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shiftReg;
    w_bitNext   = r_bitCnt;
    w_divNext   = r_divCnt;
    w_readyNext = r_ready;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    w_sclkNext  = r_sclk;
    w_csNNext   = r_csN;
    w_selNext   = r_sel;

    case (r_state)
      ST_IDLE: begin
        w_divNext = '0;
        if (valid_in) begin
          w_stateNext = ST_SETUP;
          w_shiftNext = data_in;
          w_bitNext   = BIT_LAST;
          w_csNNext   = 1'b0;
          w_selNext   = 1'b0;
          w_readyNext = 1'b0;
          w_busyNext  = 1'b1;
          w_sclkNext  = 1'b0;
        end
      end

      ST_SETUP: begin
        if (w_divLast) begin
          w_stateNext = ST_HIGH;
          w_divNext   = '0;
          w_sclkNext  = 1'b1;
        end else begin
          w_divNext = r_divCnt + CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (w_divLast) begin
          w_divNext  = '0;
          w_sclkNext = 1'b0;
          if (r_bitCnt == '0) begin
            w_stateNext = ST_HOLD;
          end else begin
            w_stateNext = ST_LOW;
            w_shiftNext = {r_shiftReg[DATA_WIDTH-2:0], 1'b0};
            w_bitNext   = r_bitCnt - BIT_W'(1);
          end
        end else begin
          w_divNext = r_divCnt + CNT_W'(1);
        end
      end

      ST_LOW: begin
        if (w_divLast) begin
          w_stateNext = ST_HIGH;
          w_divNext   = '0;
          w_sclkNext  = 1'b1;
        end else begin
          w_divNext = r_divCnt + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (w_divLast) begin
          w_stateNext = ST_DONE;
          w_divNext   = '0;
          w_doneNext  = 1'b1;
          w_csNNext   = 1'b1;
          w_selNext   = 1'b1;
          w_shiftNext = '0;
          w_busyNext  = 1'b1;
          w_readyNext = 1'b0;
        end else begin
          w_divNext = r_divCnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        w_stateNext = ST_IDLE;
        w_divNext   = '0;
        w_readyNext = 1'b1;
        w_busyNext  = 1'b0;
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_shiftNext = '0;
        w_bitNext   = '0;
        w_divNext   = '0;
        w_readyNext = 1'b1;
        w_busyNext  = 1'b0;
        w_sclkNext  = 1'b0;
        w_csNNext   = 1'b1;
        w_selNext   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer at once, with no done pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_divCnt   <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_csN      <= 1'b1;
      r_sel      <= 1'b1;
    end else begin
      r_state    <= w_stateNext;
      r_shiftReg <= w_shiftNext;
      r_bitCnt   <= w_bitNext;
      r_divCnt   <= w_divNext;
      r_ready    <= w_readyNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_sclk     <= w_sclkNext;
      r_csN      <= w_csNNext;
      r_sel      <= w_selNext;
    end
  end

  assign ready_out = r_ready;
  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign sclk_out  = r_sclk;
  assign cs_n_out  = r_csN;
  assign mosi_out  = r_shiftReg[DATA_WIDTH-1];
  assign sel_out   = r_sel;

endmodule

// File: tb/tb_spi_tx_shifter.sv
// tb_spi_tx_shifter: scoreboard bench for spi_tx_shifter.
// Two instances run side by side: the default 8-bit / divide-by-4 build, and
// a 16-bit / divide-by-1 build.
// The reference model works at transaction level. A word is taken only when
// the previous transfer plus its DONE and IDLE cycles has finished. The edge
// numbers at which cs_n falls and done pulses follow from (2*W+1)*D.
// With accept at edge N, done_out is set by edge N+(2*W+1)*D. It is high
// during the cycle that ends at edge N+(2*W+1)*D+1.
module tb_spi_tx_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    int          acceptAt;
  } txn_t;

  // One comparison: count it, and report it if it disagrees
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int W      = (g == 0) ? 8 : 16;
    localparam int D      = (g == 0) ? 4 : 1;
    localparam int TX_LEN = (2 * W + 1) * D;

    logic         rst;
    logic         valid;
    logic [W-1:0] data;
    logic ready, busy, done, sclk, csN, mosi, sel;
    bit   finished = 1'b0;

    spi_tx_shifter #(.DATA_WIDTH(W), .CLK_DIV(D)) dut (
      .clk_in   (clk),
      .rst_in   (rst),
      .data_in  (data),
      .valid_in (valid),
      .ready_out(ready),
      .busy_out (busy),
      .done_out (done),
      .sclk_out (sclk),
      .cs_n_out (csN),
      .mosi_out (mosi),
      .sel_out  (sel)
    );

    int   edgeCnt     = 0;
    int   nextFree    = 0;
    int   acceptCnt   = 0;
    int   lastRstEdge = -10;
    bit   modelOn     = 1'b0;
    txn_t expQ[$];

    // Transaction model: at each edge it decides whether the word on data is taken
    initial forever begin
      @(posedge clk);
      edgeCnt++;
      if (rst) begin
        expQ.delete();
        nextFree    = edgeCnt + 1;
        lastRstEdge = edgeCnt;
        modelOn     = 1'b1;
      end else if (modelOn && valid && edgeCnt >= nextFree) begin
        expQ.push_back('{word: 32'(data), acceptAt: edgeCnt});
        nextFree = edgeCnt + TX_LEN + 2;
        acceptCnt++;
      end
    end

    logic [W-1:0] cap = '0;
    int   riseCnt  = 0;
    int   highLen  = 0;
    logic prevSclk = 1'b0;
    logic prevCsN  = 1'b1;
    logic prevDone = 1'b0;
    txn_t t;

    // Monitor: samples on the falling clock edge, acts as the SPI slave and scores each done pulse
    initial forever begin
      @(negedge clk);
      if (modelOn) begin
        compare("ready", 32'(ready), 32'(edgeCnt >= nextFree - 1));
        compare("busy", 32'(busy), 32'(edgeCnt < nextFree - 1));
        compare("sel_vs_csn", 32'(sel), 32'(csN));
        if (csN) compare("idle_lines", 32'({sclk, mosi}), 32'(0));
        if (!csN && prevCsN) begin
          riseCnt = 0;
          cap     = '0;
          compare("accept_edge", 32'(edgeCnt),
                  (expQ.size() > 0) ? 32'(expQ[$].acceptAt) : 32'hFFFF_FFFF);
        end
        if (sclk && !prevSclk) begin
          cap = {cap[W-2:0], mosi};
          riseCnt++;
          highLen = 0;
          compare("cs_at_rise", 32'(csN), 32'(0));
        end
        if (sclk) highLen++;
        if (!sclk && prevSclk && lastRstEdge != edgeCnt)
          compare("sclk_high_len", 32'(highLen), 32'(D));
        if (done) begin
          compare("done_width", 32'(prevDone), 32'(0));
          compare("cs_at_done", 32'(csN), 32'(1));
          compare("pending_at_done", 32'(expQ.size()), 32'(1));
          if (expQ.size() > 0) begin
            t = expQ.pop_front();
            compare("rx_word", 32'(cap), t.word);
            compare("rise_count", 32'(riseCnt), 32'(W));
            compare("done_edge", 32'(edgeCnt), 32'(t.acceptAt + TX_LEN));
          end
        end
      end
      prevSclk = sclk;
      prevCsN  = csN;
      prevDone = done;
    end

    // Offers one word with valid high across exactly one rising edge
    task automatic applyStimulus(input logic [W-1:0] word);
      @(posedge clk);
      #1;
      data  = word;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
    endtask

    // Checks that the output lines are at their idle/reset values
    task automatic checkOutput(input string tag);
      compare(tag, 32'({ready, csN, sclk, sel, mosi, done}), 32'(6'b110100));
    endtask

    // Waits until the model says the next offered word will be taken
    task automatic waitFree();
      int guard = 0;
      while (edgeCnt + 1 < nextFree && guard < 1000) begin
        @(posedge clk);
        guard++;
      end
      #1;
    endtask

    task automatic waitDrain();
      waitFree();
      repeat (4) @(posedge clk);
      compare("queue_drained", 32'(expQ.size()), 32'(0));
    endtask

    task automatic resetPulse(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
    endtask

    if (g == 0) begin : gStim
      // Directed cases for the default build, followed by random traffic
      initial begin
        int startCnt;
        int guard;
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        resetPulse(2);
        @(negedge clk);
        checkOutput("reset_values");

        applyStimulus(8'hA5);
        waitFree();

        // valid held high: the second word must be taken two edges after done
        @(posedge clk);
        #1;
        data     = 8'hFF;
        valid    = 1'b1;
        startCnt = acceptCnt;
        guard    = 0;
        while (acceptCnt < startCnt + 1 && guard < 300) begin
          @(posedge clk);
          #1;
          guard++;
        end
        data = 8'h00;
        while (acceptCnt < startCnt + 2 && guard < 600) begin
          @(posedge clk);
          #1;
          guard++;
        end
        valid = 1'b0;
        waitFree();

        // A word offered mid-transfer is dropped
        applyStimulus(8'h5A);
        repeat (20) @(posedge clk);
        applyStimulus(8'h3C);
        waitFree();

        // Reset after the third sclk rise aborts the transfer without a done pulse
        applyStimulus(8'hC3);
        guard = 0;
        while (riseCnt < 3 && guard < 200) begin
          @(negedge clk);
          #1;
          guard++;
        end
        compare("third_rise_seen", 32'(riseCnt >= 3), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_values");
        waitFree();
        applyStimulus(8'h81);
        waitFree();

        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          applyStimulus(W'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 60)) @(posedge clk);
            applyStimulus(W'($urandom));
          end
          waitFree();
        end
        waitDrain();
        finished = 1'b1;
      end
    end else begin : gStim
      // Wide word with the fastest divider: sclk toggles every clock
      initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        resetPulse(2);
        @(negedge clk);
        checkOutput("reset_values_w16");
        applyStimulus(16'h8001);
        waitFree();
        for (int i = 0; i < 8; i++) begin
          applyStimulus(W'($urandom));
          if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 30)) @(posedge clk);
            applyStimulus(W'($urandom));
          end
          waitFree();
        end
        waitDrain();
        finished = 1'b1;
      end
    end
  end

  initial begin
    wait (gInst[0].finished && gInst[1].finished);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: actual still running, required finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
